// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM states, data width, clocks-per-bit helper.
// PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } uart_state_e;

    function automatic int cpb_calc(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-to-consumer byte handshake plus error pulses.
// Master drives data/status, slave returns rx_ack.
interface uart_rx_if;

    logic [uart_pkg::DATA_W-1:0] rx_data;
    logic                        rx_valid;
    logic                        rx_ack;
    logic                        frame_err;
    logic                        overrun;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        input  rx_ack
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        output rx_ack
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; 2-cycle latency, no backpressure.
// Both flops reset to RST_VAL so an idle-high line reads idle straight out of reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver (8E1 with UART_RX_PARITY_EN); byte valid one clock after the stop-bit sample.
// No backpressure: an unacked byte is overwritten by the next good one and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 27000000,
    parameter int BAUD   = 115200
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      rx_in,
    uart_rx_if.master rx_bus
);

    localparam int CPB  = cpb_calc(CLK_HZ, BAUD);
    localparam int TW   = $clog2(CPB) + 1;
    localparam int BW   = $clog2(DATA_W);
    localparam logic [TW-1:0] CPB_LAST  = TW'(CPB - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CPB / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

    logic rx_s;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (rx_in),
        .q_o     (rx_s)
    );

    uart_state_e       state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              prev_q;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;
    logic              ovr_q, ovr_d;
    logic              stop_bad;
`ifdef UART_RX_PARITY_EN
    logic              par_err_q, par_err_d;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            prev_q  <= 1'b1;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            prev_q  <= rx_s;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    // A parity mismatch is folded into the stop-bit verdict so both errors share one path.
`ifdef UART_RX_PARITY_EN
    assign stop_bad = !rx_s || par_err_q;
`else
    assign stop_bad = !rx_s;
`endif

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_d = par_err_q;
`endif

        if (valid_q && rx_bus.rx_ack) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (prev_q && !rx_s) begin
                    state_d = START;
                    timer_d = '0;
                end
            end

            START: begin
                if (timer_q == HALF_LAST) begin
                    timer_d = '0;
                    bit_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            DATA: begin
                if (timer_q == CPB_LAST) begin
                    timer_d = '0;
                    shift_d = {rx_s, shift_q[DATA_W-1:1]};
                    bit_d   = bit_q + BW'(1);
                    if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (timer_q == CPB_LAST) begin
                    timer_d   = '0;
                    par_err_d = (^shift_q) ^ rx_s;
                    state_d   = STOP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
`endif

            STOP: begin
                if (timer_q == CPB_LAST) begin
                    timer_d = '0;
                    if (stop_bad) begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_IDLE;
                    end else begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        ovr_d   = valid_q && !rx_bus.rx_ack;
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            WAIT_IDLE: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rx_bus.rx_data   = data_q;
    assign rx_bus.rx_valid  = valid_q;
    assign rx_bus.frame_err = ferr_q;
    assign rx_bus.overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed table, corner sequences, and random frames vs a byte-level model.
module tb_uart_rx;

    localparam int CLK_HZ = 27000000;
    localparam int BAUD   = 115200;
    localparam int CPB    = CLK_HZ / BAUD;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic rx_line = 1'b1;
    logic man_ack = 1'b0;
    logic auto_ack = 1'b0;
    bit   auto_en = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    uart_rx_if bus ();

    assign bus.rx_ack = auto_en ? auto_ack : man_ack;

    uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rx_in   (rx_line),
        .rx_bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.frame_err) ferr_cnt <= ferr_cnt + 1;
        if (bus.overrun)   ovr_cnt  <= ovr_cnt + 1;
    end

    // Consumer: records every byte it sees and acks within 1..9 clocks.
    initial begin
        forever begin
            @(negedge clk);
            if (auto_en && bus.rx_valid) begin
                got_q.push_back(bus.rx_data);
                repeat ($urandom_range(0, 8)) @(negedge clk);
                auto_ack = 1'b1;
                @(negedge clk);
                auto_ack = 1'b0;
            end
        end
    end

    initial begin
        #(950_000);
        $display("FAIL watchdog: simulation time limit reached, got %0d failures so far, required completion", n_fail);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic line_bit(input logic v);
        rx_line = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok, input int idle_bits);
        logic pbit;
        pbit = (^d) ^ ~par_ok;
        line_bit(1'b0);
        for (int i = 0; i < 8; i++) line_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        line_bit(pbit);
`endif
        line_bit(stop_ok);
        rx_line = 1'b1;
        repeat (idle_bits) line_bit(1'b1);
    endtask

    task automatic pulse_ack();
        man_ack = 1'b1;
        @(posedge clk);
        #1;
        man_ack = 1'b0;
    endtask

    typedef struct {
        logic [7:0] d;
        bit         stop_ok;
        bit         ack_after;
        logic [7:0] exp_data;
        bit         exp_valid;
        int         exp_ferr;
        int         exp_ovr;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int f0, o0, c0, lat, nrand;
        bit found;
        logic [7:0] d;
        bit stop_ok, par_ok;
        logic [7:0] hello[6];

        tbl[0] = '{8'h55, 1'b1, 1'b0, 8'h55, 1'b1, 0, 0};
        tbl[1] = '{8'hAA, 1'b1, 1'b1, 8'hAA, 1'b1, 0, 1};
        tbl[2] = '{8'h41, 1'b0, 1'b0, 8'hAA, 1'b0, 1, 0};
        tbl[3] = '{8'h42, 1'b1, 1'b1, 8'h42, 1'b1, 0, 0};
        tbl[4] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 0, 0};
        tbl[5] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 0, 1};
        hello = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0A};

        // Reset values
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_data", 32'(bus.rx_data), 32'h0);
        check("rst_valid", 32'(bus.rx_valid), 32'h0);
        check("rst_ferr", 32'(bus.frame_err), 32'h0);
        check("rst_ovr", 32'(bus.overrun), 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;

        // Single byte, latency about 9.5 bit times after the start edge
        f0 = ferr_cnt;
        c0 = cyc;
        lat = 0;
        found = 1'b0;
        fork
            send_frame(8'h68, 1'b1, 1'b1, 0);
            begin
                for (int i = 0; i < 12 * CPB; i++) begin
                    @(negedge clk);
                    if (!found && bus.rx_valid) begin
                        found = 1'b1;
                        lat = cyc - c0;
                    end
                end
            end
        join
        check("first_valid_seen", 32'(found), 32'h1);
        check("first_latency_window", 32'(lat >= (19 * CPB) / 2 - 20 && lat <= (19 * CPB) / 2 + 20), 32'h1);
        check("first_data", 32'(bus.rx_data), 32'h68);
        check("first_ferr", 32'(ferr_cnt - f0), 32'h0);
        pulse_ack();
        @(negedge clk);
        check("first_ackclr", 32'(bus.rx_valid), 32'h0);
        #1;

        // Directed table: overrun, framing error, recovery
        for (int k = 0; k < 6; k++) begin
            f0 = ferr_cnt;
            o0 = ovr_cnt;
            send_frame(tbl[k].d, tbl[k].stop_ok, 1'b1, 1);
            @(negedge clk);
            check($sformatf("tbl%0d_data", k), 32'(bus.rx_data), 32'(tbl[k].exp_data));
            check($sformatf("tbl%0d_valid", k), 32'(bus.rx_valid), 32'(tbl[k].exp_valid));
            check($sformatf("tbl%0d_ferr", k), 32'(ferr_cnt - f0), 32'(tbl[k].exp_ferr));
            check($sformatf("tbl%0d_ovr", k), 32'(ovr_cnt - o0), 32'(tbl[k].exp_ovr));
            #1;
            if (tbl[k].ack_after) begin
                pulse_ack();
                @(negedge clk);
                check($sformatf("tbl%0d_ackclr", k), 32'(bus.rx_valid), 32'h0);
                #1;
            end
        end

        // 50-clock glitch is rejected, then a real frame still lands
        f0 = ferr_cnt;
        rx_line = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        rx_line = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        @(negedge clk);
        check("glitch_valid", 32'(bus.rx_valid), 32'h0);
        check("glitch_ferr", 32'(ferr_cnt - f0), 32'h0);
        #1;
        send_frame(8'h5A, 1'b1, 1'b1, 0);
        @(negedge clk);
        check("post_glitch_data", 32'(bus.rx_data), 32'h5A);
        check("post_glitch_valid", 32'(bus.rx_valid), 32'h1);
        #1;
        pulse_ack();
        repeat (5) @(posedge clk);
        #1;

        // "hello\n" back to back with the acking consumer
        o0 = ovr_cnt;
        got_q.delete();
        auto_en = 1'b1;
        for (int k = 0; k < 6; k++) send_frame(hello[k], 1'b1, 1'b1, 0);
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("hello_count", 32'(got_q.size()), 32'd6);
        for (int k = 0; k < 6; k++)
            if (k < got_q.size()) check($sformatf("hello_byte%0d", k), 32'(got_q[k]), 32'(hello[k]));
        check("hello_ovr", 32'(ovr_cnt - o0), 32'h0);
        #1;

        // Random frames; model: a byte is delivered iff its stop (and parity) are good, else one error pulse
        got_q.delete();
        exp_q.delete();
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        nrand = 0;
        for (int k = 0; k < 6; k++) begin
            d = 8'($urandom);
            stop_ok = ($urandom_range(0, 3) != 0);
`ifdef UART_RX_PARITY_EN
            par_ok = ($urandom_range(0, 3) != 0);
`else
            par_ok = 1'b1;
`endif
            if (stop_ok && par_ok) exp_q.push_back(d);
            else nrand++;
            send_frame(d, stop_ok, par_ok, (stop_ok && par_ok) ? 0 : 1);
        end
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("rand_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++)
            if (k < got_q.size()) check($sformatf("rand_byte%0d", k), 32'(got_q[k]), 32'(exp_q[k]));
        check("rand_ferr", 32'(ferr_cnt - f0), 32'(nrand));
        check("rand_ovr", 32'(ovr_cnt - o0), 32'h0);
        #1;
        auto_en = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // Reset during bit 4 discards the partial byte
        line_bit(1'b0);
        for (int i = 0; i < 4; i++) line_bit(1'(8'hC3 >> i));
        rx_line = 1'b0;
        repeat (CPB / 2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        rx_line = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("midrst_data", 32'(bus.rx_data), 32'h0);
        check("midrst_valid", 32'(bus.rx_valid), 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        f0 = ferr_cnt;
        repeat (2 * CPB) @(posedge clk);
        @(negedge clk);
        check("midrst_idle_valid", 32'(bus.rx_valid), 32'h0);
        #1;
        send_frame(8'h3C, 1'b1, 1'b1, 0);
        @(negedge clk);
        check("midrst_new_data", 32'(bus.rx_data), 32'h3C);
        check("midrst_new_valid", 32'(bus.rx_valid), 32'h1);
        check("midrst_ferr", 32'(ferr_cnt - f0), 32'h0);
        #1;
        pulse_ack();
        repeat (5) @(posedge clk);
        #1;

`ifdef UART_RX_PARITY_EN
        // Bad parity with a good stop bit is a framing error
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b1, 1'b0, 1);
        @(negedge clk);
        check("par_ferr", 32'(ferr_cnt - f0), 32'h1);
        check("par_valid", 32'(bus.rx_valid), 32'h0);
        check("par_data", 32'(bus.rx_data), 32'h3C);
        #1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
